// File: rtl/fpu_share_arbiter_if.sv
// Bundle of the two requester ports and the shared FPU port.
// slave is the arbiter's view; master is the requester/FPU side view.
interface fpu_share_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [1:0]  req0_op;
  logic        resp0_valid;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [1:0]  req1_op;
  logic        resp1_valid;
  logic [31:0] resp_r;
  logic        resp_err;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [1:0]  fpu_op;
  logic        fpu_start;
  logic        fpu_done;
  logic [31:0] fpu_r;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  fpu_done, fpu_r,
    output req0_ready, resp0_valid,
    output req1_ready, resp1_valid,
    output resp_r, resp_err,
    output fpu_a, fpu_b, fpu_op, fpu_start
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output fpu_done, fpu_r,
    input  req0_ready, resp0_valid,
    input  req1_ready, resp1_valid,
    input  resp_r, resp_err,
    input  fpu_a, fpu_b, fpu_op, fpu_start
  );
endinterface

// File: rtl/fpu_share_arbiter.sv
// Round-robin share of one FPU between two requesters.
// Define FPU_TIMEOUT_EN to add a done watchdog returning NAN_RESULT.
module fpu_share_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NAN_RESULT     = 32'h7FC0_0000
) (
  input logic               clk,
  input logic               rst,
  fpu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] r_q, r_d;
  logic        grant0, grant1;

`ifdef FPU_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 255) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`else
  logic unused_params;
  assign unused_params = (TIMEOUT_CYCLES != 0) ^
                         (NAN_RESULT != '0);
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    r_d     = r_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
`ifdef FPU_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        // on a tie the port that did not win last time goes
        if (!rst) begin
          if (bus.req0_valid &&
              (!bus.req1_valid || last_q))
            grant0 = 1'b1;
          else if (bus.req1_valid)
            grant1 = 1'b1;
        end
        if (grant0 || grant1) begin
          owner_d = grant1;
          last_d  = grant1;
          a_d     = grant1 ? bus.req1_a  : bus.req0_a;
          b_d     = grant1 ? bus.req1_b  : bus.req0_b;
          op_d    = grant1 ? bus.req1_op : bus.req0_op;
          state_d = START;
        end
      end
      START: begin
        state_d = WAIT;
`ifdef FPU_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        // done beats the watchdog when both land together
        if (bus.fpu_done) begin
          r_d     = bus.fpu_r;
          state_d = RESP;
`ifdef FPU_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q == LIMIT) begin
          r_d     = NAN_RESULT;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
`else
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      r_q     <= r_d;
    end
  end

`ifdef FPU_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.resp_err = err_q;
`else
  assign bus.resp_err = 1'b0;
`endif

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.resp0_valid = (state_q == RESP) && !owner_q;
  assign bus.resp1_valid = (state_q == RESP) && owner_q;
  assign bus.resp_r      = r_q;
  assign bus.fpu_a       = a_q;
  assign bus.fpu_b       = b_q;
  assign bus.fpu_op      = op_q;
  assign bus.fpu_start   = (state_q == START);

endmodule
